jhonson2_cnt: RTL and testbench
===============================

JHONSON2_CNT -- requirements
Module: jhonson2_cnt

Interface
REQ-001 The block SHALL have one parameter: DIV_N, default 1, the number of clk cycles per counter step (legal range 1..256).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: the reset, asynchronous and active-high (n_rst=1 resets, despite the name).
REQ-004 The block SHALL have port result0, output, 1 bit: counter bit 0 (LSB).
REQ-005 The block SHALL have port result1, output, 1 bit: counter bit 1.
REQ-006 The block SHALL have port result2, output, 1 bit: counter bit 2.
REQ-007 The block SHALL have port result3, output, 1 bit: counter bit 3 (MSB).

Function
REQ-008 The block SHALL implement a 4-bit twisted-ring (Johnson) counter Q = {result3,result2,result1,result0}, driven directly from flops with no combinational output logic.
REQ-009 On each step, the block SHALL load Q_next = {Q[2:0], ~Q[3]} (shift toward MSB; inverted MSB enters at LSB).
REQ-010 From 0000, the legal sequence SHALL be 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000 (period 8 steps).
REQ-011 A step SHALL occur on a rising clk edge when the internal prescaler tick is high; with DIV_N=1 the tick is constantly high and Q advances every cycle.
REQ-012 With DIV_N>1, the prescaler SHALL count 0..DIV_N-1 and wrap, asserting the tick on the cycle its count equals DIV_N-1, so Q advances once every DIV_N cycles.
REQ-013 The first step after reset release SHALL occur DIV_N rising edges after release.
REQ-014 Illegal states (any of the 8 patterns not listed in REQ-010, e.g. 0101, 1010, 0010) SHALL be detected, and the next step SHALL load 0000 instead of the shifted value.
REQ-015 Illegal-state recovery SHALL complete in exactly one step; Q SHALL never remain in an illegal state across two steps.
REQ-016 Between steps, Q SHALL hold its value.

Reset
REQ-017 While n_rst=1, Q SHALL be 0000 and the prescaler count SHALL be 0, regardless of clk.
REQ-018 Asserting n_rst mid-sequence SHALL clear Q to 0000 immediately, without waiting for a clk edge.
REQ-019 After n_rst deasserts, counting SHALL resume from 0000 per REQ-013.

Structure
REQ-020 A shared package jhonson2_pkg SHALL hold the state width (4), the reset state (4'b0000), and the table of the 8 legal states.
REQ-021 The prescaler SHALL be a sub-module jhonson2_tick (parameter DIV_N; ports clk, n_rst, tick).
REQ-022 The state register, next-state shift and legality check SHALL reside in jhonson2_cnt.

Verification
REQ-023 Reset check: with DIV_N=1 and n_rst=1 held for 10 ns with a 10 ns clk -> Q=0000 throughout, including between clk edges.
REQ-024 Sequence check: with DIV_N=1, release reset and apply 16 edges -> Q=0001,0011,0111,1111,1110,1100,1000,0000, repeated twice.
REQ-025 Async reset check: assert n_rst between clk edges while Q=0111 -> Q=0000 before the next edge; after release, the first edge gives 0001.
REQ-026 Illegal-state check: force Q=0101 and release -> the next step gives 0000, then 0001.
REQ-027 Prescaler check: with DIV_N=3 and reset released -> Q changes only on edges 3, 6, 9, ... (0001, 0011, 0111) and holds on all other edges.
REQ-028 Long run: run 200 ns at DIV_N=1 -> Q is always one of the 8 legal states, and every transition matches REQ-009.

Source files
------------

// File: rtl/jhonson2_pkg.sv
// rtl/jhonson2_pkg.sv - shared constants and helpers for the Johnson counter
//
// Purpose: holds the state width, reset state and the table of the eight
// legal twisted-ring states, plus small helpers used by the counter.
// Ports: none (package).

package jhonson2_pkg;

  localparam int STATE_W = 4;

  typedef logic [STATE_W-1:0] jstate_t;

  localparam jstate_t RESET_STATE = 4'b0000;

  localparam int NUM_LEGAL = 8;

  // Legal sequence in stepping order, starting from the reset state.
  localparam jstate_t LEGAL_STATES [NUM_LEGAL] = '{
    4'b0000,
    4'b0001,
    4'b0011,
    4'b0111,
    4'b1111,
    4'b1110,
    4'b1100,
    4'b1000
  };

  // True when s is one of the eight states the ring is allowed to visit.
  function automatic logic is_legal(input jstate_t s);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL; i++) begin
      if (s == LEGAL_STATES[i]) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // One twisted-ring step: shift toward the MSB, inverted MSB enters at LSB.
  function automatic jstate_t johnson_shift(input jstate_t s);
    return {s[STATE_W-2:0], ~s[STATE_W-1]};
  endfunction

endpackage

// File: rtl/jhonson2_cnt_if.sv
// rtl/jhonson2_cnt_if.sv - bundle of the four counter output bits
//
// Purpose: groups the counter result bits so a consumer can take them as
// one connection.
// Signals: result0 (LSB) .. result3 (MSB).
// Modports: master drives the bits, slave observes them.

interface jhonson2_cnt_if;

  logic result0;
  logic result1;
  logic result2;
  logic result3;

  modport master (
    output result0,
    output result1,
    output result2,
    output result3
  );

  modport slave (
    input result0,
    input result1,
    input result2,
    input result3
  );

endinterface

// File: rtl/jhonson2_tick.sv
// rtl/jhonson2_tick.sv - step prescaler for the Johnson counter
//
// Purpose: produces a one-cycle step enable every DIV_N clk cycles.
// Parameters: DIV_N - clk cycles per step (1..256).
// Ports:
//   clk   - clock, rising edge
//   n_rst - asynchronous reset, active HIGH despite the name
//   tick  - high on the cycle the counter should step

module jhonson2_tick #(
  parameter int DIV_N = 1
) (
  input  logic clk,
  input  logic n_rst,
  output logic tick
);

  // A one-bit counter is kept even for DIV_N=1: it sits at 0, which equals
  // the terminal value, so tick is constantly high without a special case.
  localparam int CW = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_N - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Count starts at 0 after release, so the first tick lands on the
  // DIV_N-th rising edge.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/jhonson2_cnt.sv
// rtl/jhonson2_cnt.sv - 4-bit self-correcting Johnson counter
//
// Purpose: twisted-ring counter stepping once every DIV_N clk cycles; any
// state outside the eight-state ring is replaced by 0000 on the next step.
// Parameters: DIV_N - clk cycles per step (1..256).
// Ports:
//   clk     - clock, rising edge
//   n_rst   - asynchronous reset, active HIGH despite the name
//   result0 - counter bit 0 (LSB)
//   result1 - counter bit 1
//   result2 - counter bit 2
//   result3 - counter bit 3 (MSB)

module jhonson2_cnt #(
  parameter int DIV_N = 1
) (
  input  logic clk,
  input  logic n_rst,
  output logic result0,
  output logic result1,
  output logic result2,
  output logic result3
);

  import jhonson2_pkg::*;

  jstate_t q_reg;
  jstate_t q_next;
  logic    q_legal;
  logic    tick;

  jhonson2_tick #(
    .DIV_N (DIV_N)
  ) u_tick (
    .clk   (clk),
    .n_rst (n_rst),
    .tick  (tick)
  );

  // Off-ring states collapse to the reset state in a single step, so the
  // ring is re-entered at a known point.
  always_comb begin
    q_legal = is_legal(q_reg);
    q_next  = RESET_STATE;
    if (q_legal) begin
      q_next = johnson_shift(q_reg);
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      q_reg <= RESET_STATE;
    end else if (tick) begin
      q_reg <= q_next;
    end
  end

  assign result0 = q_reg[0];
  assign result1 = q_reg[1];
  assign result2 = q_reg[2];
  assign result3 = q_reg[3];

endmodule

// File: tb/tb_jhonson2_cnt.sv
// tb/tb_jhonson2_cnt.sv - directed self-checking bench for jhonson2_cnt

module tb_jhonson2_cnt;

  logic clk = 1'b0;
  logic rst;
  logic rst3;

  always #5 clk = ~clk;

  jhonson2_cnt_if bus1 ();
  jhonson2_cnt_if bus3 ();

  jhonson2_cnt #(.DIV_N(1)) dut1 (
    .clk     (clk),
    .n_rst   (rst),
    .result0 (bus1.result0),
    .result1 (bus1.result1),
    .result2 (bus1.result2),
    .result3 (bus1.result3)
  );

  jhonson2_cnt #(.DIV_N(3)) dut3 (
    .clk     (clk),
    .n_rst   (rst3),
    .result0 (bus3.result0),
    .result1 (bus3.result1),
    .result2 (bus3.result2),
    .result3 (bus3.result3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] q1();
    return {bus1.result3, bus1.result2, bus1.result1, bus1.result0};
  endfunction

  function automatic logic [3:0] q3();
    return {bus3.result3, bus3.result2, bus3.result1, bus3.result0};
  endfunction

  logic [3:0] seq_exp [8];
  logic [3:0] div3_exp [9];
  logic [3:0] prev;
  logic [3:0] cur;
  logic       legal;

  initial begin
    seq_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                4'b1110, 4'b1100, 4'b1000, 4'b0000};
    div3_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                 4'b0011, 4'b0011, 4'b0011, 4'b0111};

    rst  = 1'b1;
    rst3 = 1'b1;

    // Reset held for 10 ns, sampled between and across the edge at 5 ns.
    #1 check("rst_t1", q1(), 4'b0000);
    #3 check("rst_t4", q1(), 4'b0000);
    #2 check("rst_t6", q1(), 4'b0000);
    #3 check("rst_t9", q1(), 4'b0000);
    check("rst3_t9", q3(), 4'b0000);

    // Release on the falling edge, then two full periods of the ring.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 check($sformatf("seq_e%0d", i + 1), q1(), seq_exp[i % 8]);
    end

    // Long run: every state legal, every transition a Johnson shift.
    prev = q1();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cur   = q1();
      legal = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (cur == seq_exp[k]) legal = 1'b1;
      end
      check($sformatf("long_legal%0d", i), {3'b000, legal}, 4'b0001);
      check($sformatf("long_step%0d", i), cur, {prev[2:0], ~prev[3]});
      prev = cur;
    end

    // Plant an illegal state between edges.
    @(negedge clk);
    force dut1.q_reg = 4'b0101;
    #1;
    check("ill_forced", q1(), 4'b0101);
    release dut1.q_reg;
    #1 check("ill_held", q1(), 4'b0101);
    @(posedge clk);
    #1 check("ill_recover", q1(), 4'b0000);
    @(posedge clk);
    #1 check("ill_next", q1(), 4'b0001);

    // Walk to 0111, then reset between edges.
    @(posedge clk);
    #1 check("ar_pre1", q1(), 4'b0011);
    @(posedge clk);
    #1 check("ar_pre2", q1(), 4'b0111);
    #2 rst = 1'b1;
    #1 check("ar_async", q1(), 4'b0000);
    @(posedge clk);
    #1 check("ar_hold", q1(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("ar_first", q1(), 4'b0001);

    // DIV_N=3 instance: steps only on edges 3, 6, 9.
    @(negedge clk);
    check("div3_rst", q3(), 4'b0000);
    rst3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1 check($sformatf("div3_e%0d", i + 1), q3(), div3_exp[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
